hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Decides per cycle whether to freeze PC and IF/ID, inject a bubble into ID/EX, or flush IF/ID on a taken early-resolved beq.
- Covers hazards that operand forwarding cannot resolve: load-use, branch-in-ID operand dependencies, and a multi-cycle multiply/divide unit (MDU).
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- MDU_LAT, 4: MDU busy cycles per multiply/divide, including the issue cycle. Legal range 2..15.
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- IF_ID_Rs  in  5  rs of the instruction in ID
- IF_ID_Rt  in  5  rt of the instruction in ID
- ID_uses_rt  in  1  ID instruction reads rt as a source
- ID_branch  in  1  ID instruction is beq/bne (compared in ID)
- ID_mdu_start  in  1  ID instruction is mult/div
- ID_reads_hilo  in  1  ID instruction is mfhi/mflo
- ID_EX_Rd  in  5  destination register in EX
- ID_EX_regWrite  in  1  EX instruction writes the register file
- ID_EX_memRead  in  1  EX instruction is a load
- EX_MEM_Rd  in  5  destination register in MEM
- EX_MEM_memRead  in  1  MEM instruction is a load
- branch_taken  in  1  ID comparator result, valid when ID_branch=1
- pc_write  out  1  1 = PC may update
- if_id_write  out  1  1 = IF/ID may load
- id_ex_bubble  out  1  1 = ID/EX loads a NOP (control signals zeroed)
- if_id_flush  out  1  1 = IF/ID loads a NOP
- mdu_busy  out  1  MDU occupied
- stall_cycles  out  CNT_W  saturating count of stall cycles

Behaviour:
- Clock, reset and state
  - One clock domain. Reset is synchronous, active-low.
  - Registered state: fsm (RUN, BR_LOAD2), mdu_cnt (4 bits), stall_cycles.
  - On a clk edge with rst_n=0: fsm=RUN, mdu_cnt=0, stall_cycles=0.
  - While rst_n=0, outputs are forced: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=1, mdu_busy=0.
- Hazard terms (combinational; all register matches require Rd!=0; "match" means Rd==IF_ID_Rs, or Rd==IF_ID_Rt with ID_uses_rt=1)
  - lu = ID_EX_memRead & match(ID_EX_Rd)
  - br_alu = ID_branch & ID_EX_regWrite & !ID_EX_memRead & match(ID_EX_Rd)
  - br_ld1 = ID_branch & ID_EX_memRead & match(ID_EX_Rd). This term is also covered by lu.
  - br_ld_mem = ID_branch & EX_MEM_memRead & match(EX_MEM_Rd)
  - mdu_hz = mdu_busy & (ID_reads_hilo | ID_mdu_start)
- stall
  - In RUN: stall = lu | br_alu | br_ld_mem | mdu_hz.
  - In BR_LOAD2: stall = 1 unconditionally.
- Outputs when rst_n=1
  - pc_write = if_id_write = !stall
  - id_ex_bubble = stall
  - if_id_flush = !stall & ID_branch & branch_taken
  - A stall suppresses the flush: the branch result is stale during a stall.
  - No output may be 1 for bubble and flush of the same register in the same cycle, except during reset.
- FSM transitions
  - RUN -> BR_LOAD2 when br_ld1 = 1.
  - BR_LOAD2 -> RUN always after one cycle.
  - A branch on the destination of a load in EX therefore stalls exactly 2 cycles. Operands then come from MEM/WB via the branch forwarding path.
- MDU counter
  - An MDU start is accepted when ID_mdu_start=1 and stall=0; mdu_cnt loads MDU_LAT-1.
  - Otherwise, when mdu_cnt!=0, mdu_cnt decrements by 1.
  - mdu_busy = (mdu_cnt!=0).
  - Independent instructions issue freely while mdu_busy=1.
  - A second mult/div while busy stalls until mdu_cnt reaches 0, then is accepted that same cycle.
- stall_cycles
  - Increments by 1 on each edge with rst_n=1 and stall=1.
  - Saturates at all-ones; does not wrap.
- Simultaneous events
  - lu and mdu_hz together: one stall cycle per cycle, counter +1 only.
  - br_ld1 while mdu_hz: FSM still enters BR_LOAD2.
  - Reset mid-BR_LOAD2 or mid-MDU: returns to RUN with mdu_cnt=0 on that edge.

Test Plan:
- lw $2 in EX (ID_EX_memRead=1, Rd=2), add reading $2 in ID -> exactly 1 cycle with pc_write=0, id_ex_bubble=1; stall_cycles=1; next cycle pc_write=1.
- lw $3 in EX, beq $3,$4 in ID -> stall 2 consecutive cycles (second in BR_LOAD2); branch_taken=1 on cycle 3 -> if_id_flush=1 for 1 cycle only; stall_cycles=2.
- add $5 in EX, beq $5,$0 in ID with branch_taken=1 during the stall -> 1 stall, if_id_flush=0 during the stall, if_id_flush=1 the next cycle.
- Rd=0 for every producer (load and ALU) with matching Rs=0 -> no stall, no bubble.
- MDU_LAT=4: mult accepted at cycle 0 -> mdu_busy=1 for cycles 1..3; independent add at cycle 1 issues; mfhi at cycle 2 stalls cycles 2-3 and issues at cycle 4; stall_cycles=2.
- Force stall for 2^CNT_W+3 cycles (CNT_W=4) -> stall_cycles holds at 15. Deassert rst_n mid-BR_LOAD2 -> next edge fsm=RUN, all counters 0, forced reset output values while low.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Hazard controller for the 5-stage MIPS core: load-use, branch-in-ID and MDU
// stalls, taken-branch flush, and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             ID_uses_rt,
  input  logic             ID_branch,
  input  logic             ID_mdu_start,
  input  logic             ID_reads_hilo,
  input  logic [4:0]       ID_EX_Rd,
  input  logic             ID_EX_regWrite,
  input  logic             ID_EX_memRead,
  input  logic [4:0]       EX_MEM_Rd,
  input  logic             EX_MEM_memRead,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned MDU_CNT_W = 4;
  localparam logic [MDU_CNT_W-1:0] MDU_LOAD = MDU_CNT_W'(MDU_LAT - 1);

  typedef enum logic {RUN, BR_LOAD2} fsm_t;

  fsm_t                 fsm_q, fsm_d;
  logic [MDU_CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;

  logic ex_match, mem_match;
  logic lu, br_alu, br_ld1, br_ld_mem, mdu_hz, busy, stall;

  // A producer matches when it writes a nonzero register the ID instruction reads.
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rt);
    return (rd != 5'd0) && ((rd == rs) || (uses_rt && (rd == rt)));
  endfunction

  always_comb begin
    ex_match  = reg_match(ID_EX_Rd, IF_ID_Rs, IF_ID_Rt, ID_uses_rt);
    mem_match = reg_match(EX_MEM_Rd, IF_ID_Rs, IF_ID_Rt, ID_uses_rt);
    busy      = (mdu_cnt_q != '0);
    lu        = ID_EX_memRead & ex_match;
    br_alu    = ID_branch & ID_EX_regWrite & ~ID_EX_memRead & ex_match;
    br_ld1    = ID_branch & ID_EX_memRead & ex_match;
    br_ld_mem = ID_branch & EX_MEM_memRead & mem_match;
    mdu_hz    = busy & (ID_reads_hilo | ID_mdu_start);
    stall     = (fsm_q == BR_LOAD2) | lu | br_alu | br_ld_mem | mdu_hz;
  end

  // Next-state: branch-on-load FSM, MDU occupancy, saturating stall counter.
  always_comb begin
    fsm_d       = RUN;
    mdu_cnt_d   = mdu_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (fsm_q == RUN && br_ld1) begin
      fsm_d = BR_LOAD2;
    end
    if (ID_mdu_start && !stall) begin
      mdu_cnt_d = MDU_LOAD;
    end else if (busy) begin
      mdu_cnt_d = mdu_cnt_q - MDU_CNT_W'(1);
    end
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q       <= RUN;
      mdu_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      fsm_q       <= fsm_d;
      mdu_cnt_q   <= mdu_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Pipeline controls act in the current cycle; reset pins them to a safe bubble/flush.
  always_comb begin
    pc_write     = rst_n & ~stall;
    if_id_write  = rst_n & ~stall;
    id_ex_bubble = ~rst_n | stall;
    if_id_flush  = ~rst_n | (~stall & ID_branch & branch_taken);
    mdu_busy     = rst_n & busy;
  end

  assign stall_cycles = stall_cnt_q;

endmodule
